seq_bit_serializer: RTL and testbench

Upstream feeder for the serial "101" sequence-detector stage. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a serial bit stream, which drives the detector's single-bit `in` input. A one-word holding register behind the shift register lets consecutive words stream with no idle cycles between them. The block also counts completed words for debug.

---
 rtl/seq_bit_serializer.sv | 93 +++++++++
 tb/tb_seq_bit_serializer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the "101" detector: valid/ready word intake,
// one-word hold buffer behind the shift register for gapless streaming.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [15:0]      words_sent
);

  // state | meaning
  // IDLE  | no data bit on bit_out; waiting for hold to fill
  // SHIFT | sh holds cnt remaining bits, current bit on bit_out
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             hold_full, hold_full_nxt;
  logic [15:0]      words_sent_nxt;
  logic             take;

  assign word_ready = rst_n & ~hold_full;
  assign take       = word_valid & word_ready;
  assign bit_valid  = (state == SHIFT);
  assign bit_out    = bit_valid ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sh         <= '0;
      hold       <= '0;
      cnt        <= '0;
      hold_full  <= 1'b0;
      words_sent <= '0;
    end else begin
      state      <= state_nxt;
      sh         <= sh_nxt;
      hold       <= hold_nxt;
      cnt        <= cnt_nxt;
      hold_full  <= hold_full_nxt;
      words_sent <= words_sent_nxt;
    end
  end

  // take and a hold->sh transfer are exclusive since ready is low while hold_full
  always_comb begin
    state_nxt      = state;
    sh_nxt         = sh;
    cnt_nxt        = cnt;
    words_sent_nxt = words_sent;
    hold_nxt       = take ? word_in : hold;
    hold_full_nxt  = hold_full | take;
    case (state)
      IDLE: begin
        if (hold_full) begin
          sh_nxt        = hold;
          cnt_nxt       = CW'(WIDTH);
          hold_full_nxt = 1'b0;
          state_nxt     = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt > CW'(1)) begin
          sh_nxt  = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
          cnt_nxt = cnt - CW'(1);
        end else begin
          words_sent_nxt = words_sent + 16'd1;
          if (hold_full) begin
            sh_nxt        = hold;
            cnt_nxt       = CW'(WIDTH);
            hold_full_nxt = 1'b0;
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: scoreboard of expected serial bits (MSB-first
// instance) plus a directed LSB-first instance with IDLE_BIT=1.
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] word_in = '0;
  logic       word_valid = 1'b0;
  logic       word_ready, bit_out, bit_valid;
  logic [15:0] words_sent;

  logic [7:0] l_word = '0;
  logic       l_valid = 1'b0;
  logic       l_ready, l_bit, l_bv;
  logic [15:0] l_ws;

  int n_checks = 0;
  int n_fail   = 0;
  int bits_seen = 0;
  int run = 0;
  int max_run = 0;
  logic q[$];

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .words_sent(words_sent)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .word_in(l_word), .word_valid(l_valid),
    .word_ready(l_ready), .bit_out(l_bit), .bit_valid(l_bv),
    .words_sent(l_ws)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard consumer: every valid bit must match the next expected bit
  always @(negedge clk) begin
    if (bit_valid) begin
      run++;
      if (run > max_run) max_run = run;
      bits_seen++;
      if (q.size() == 0) chk("spurious_bit", {15'd0, bit_valid}, 16'd0);
      else chk("serial_bit", {15'd0, bit_out}, {15'd0, q.pop_front()});
    end else begin
      run = 0;
    end
  end

  task automatic send(input logic [7:0] w);
    logic ok;
    ok = 1'b0;
    word_in = w;
    word_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (word_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    for (int i = 7; i >= 0; i--) q.push_back(w[i]);
    #1 word_valid = 1'b0;
    chk("handshake_timeout", {15'd0, ok}, 16'd1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0 && !bit_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", {15'd0, ok}, 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    logic [7:0] lw;

    // reset state
    #1;
    chk("rst_bit_valid", {15'd0, bit_valid}, 16'd0);
    chk("rst_bit_out", {15'd0, bit_out}, 16'd0);
    chk("rst_word_ready", {15'd0, word_ready}, 16'd0);
    chk("rst_words_sent", words_sent, 16'd0);
    chk("rst_lsb_idle_bit", {15'd0, l_bit}, 16'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_word_ready", {15'd0, word_ready}, 16'd1);

    // single word
    send(8'hAD);
    wait_idle();
    chk("single_words_sent", words_sent, 16'd1);
    chk("single_idle_bit_out", {15'd0, bit_out}, 16'd0);

    // back-to-back with valid held high
    max_run = 0;
    send(8'hA5);
    send(8'h5A);
    chk("b2b_ready_low", {15'd0, word_ready}, 16'd0);
    wait_idle();
    chk("b2b_gapless_run", max_run[15:0], 16'd16);
    chk("b2b_words_sent", words_sent, 16'd3);

    // backpressure: third word waits with valid high until hold frees
    send(8'h11);
    send(8'h22);
    send(8'h3C);
    wait_idle();
    chk("bp_words_sent", words_sent, 16'd6);
    @(posedge clk);
    #2;
    chk("underrun_bit_valid", {15'd0, bit_valid}, 16'd0);
    chk("underrun_bit_out", {15'd0, bit_out}, 16'd0);
    send(8'h96);
    wait_idle();
    chk("gap_words_sent", words_sent, 16'd7);

    // reset mid-word
    start = bits_seen;
    send(8'hFF);
    for (int i = 0; i < 50 && bits_seen < start + 3; i++) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_bit_valid", {15'd0, bit_valid}, 16'd0);
    chk("midrst_bit_out", {15'd0, bit_out}, 16'd0);
    chk("midrst_word_ready", {15'd0, word_ready}, 16'd0);
    chk("midrst_words_sent", words_sent, 16'd0);
    start = bits_seen;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("midrst_no_bits", bits_seen[15:0], start[15:0]);
    chk("midrst_ready", {15'd0, word_ready}, 16'd1);
    send(8'hC3);
    wait_idle();
    chk("post_rst_words_sent", words_sent, 16'd1);

    // wrap of the completion counter
    force u_msb.words_sent = 16'hFFFF;
    @(posedge clk);
    #2 release u_msb.words_sent;
    #1 chk("wrap_preload", words_sent, 16'hFFFF);
    send(8'h42);
    wait_idle();
    chk("wrap_words_sent", words_sent, 16'h0000);

    // LSB-first instance
    lw = 8'h0B;
    l_word = lw;
    l_valid = 1'b1;
    @(negedge clk);
    chk("lsb_ready", {15'd0, l_ready}, 16'd1);
    @(posedge clk);
    #1 l_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      chk("lsb_bit_valid", {15'd0, l_bv}, 16'd1);
      chk("lsb_bit", {15'd0, l_bit}, {15'd0, lw[i]});
    end
    @(posedge clk);
    #2;
    chk("lsb_end_valid", {15'd0, l_bv}, 16'd0);
    chk("lsb_idle_bit", {15'd0, l_bit}, 16'd1);
    chk("lsb_words_sent", l_ws, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
